vend_controller: RTL and testbench

VEND_CONTROLLER -- requirements
Module: vend_controller

---
 rtl/vend_controller.sv | 178 +++++++++++++++++
 tb/tb_vend_controller.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vend_controller.sv
// Vending machine transaction controller.
// Flow: select an item, fetch its record from item memory, validate it,
// collect coins until the price is covered (or the user cancels), pulse a
// dispense strobe, then return change.
// Optional feature: define VEND_TIMEOUT_EN to refund the full balance
// automatically after TIMEOUT_CYCLES coin-free cycles spent waiting in COLLECT.
module vend_controller #(
  parameter int MAX_ITEMS       = 1024,
  parameter int ITEM_ADDR_WIDTH = $clog2(MAX_ITEMS),
  parameter int TIMEOUT_CYCLES  = 1000
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       sel_valid,
  input  logic [ITEM_ADDR_WIDTH-1:0] sel_item,
  input  logic                       coin_valid,
  input  logic [15:0]                coin_value,
  input  logic                       cancel,
  input  logic [31:0]                item_data_in,
  output logic [ITEM_ADDR_WIDTH-1:0] mem_addr,
  output logic                       dispense_valid,
  output logic                       change_valid,
  output logic [15:0]                change_amount,
  output logic                       sel_error,
  output logic [15:0]                balance,
  output logic                       busy
);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] FETCH    = 3'd1;
  localparam logic [2:0] CHECK    = 3'd2;
  localparam logic [2:0] COLLECT  = 3'd3;
  localparam logic [2:0] DISPENSE = 3'd4;
  localparam logic [2:0] REFUND   = 3'd5;

  logic [2:0]                 state_reg, state_next;
  logic [ITEM_ADDR_WIDTH-1:0] addr_reg, addr_next;
  logic [15:0]                balance_reg, balance_next;
  logic [15:0]                price_reg, price_next;
  logic [15:0]                change_reg, change_next;

  // Item record fields as presented by the memory one cycle after mem_addr.
  logic [7:0]  item_dispensed;
  logic [7:0]  item_count;
  logic [15:0] item_price;
  logic        item_reject;

  // Coin crediting: balance including a coin accepted this cycle.
  logic [16:0] coin_sum;
  logic [15:0] coin_credited;
  logic        coin_accept;
  logic [15:0] balance_with_coin;

  logic timeout_hit;

  assign item_dispensed = item_data_in[31:24];
  assign item_count     = item_data_in[23:16];
  assign item_price     = item_data_in[15:0];
  // Sold out, or an unpriced (empty) slot.
  assign item_reject    = (item_dispensed >= item_count) || (item_price == 16'd0);

`ifdef VEND_TIMEOUT_EN
  logic [31:0] timeout_reg, timeout_next;

  // Coin-free cycle counter, live only while waiting in COLLECT.
  always_comb begin
    timeout_next = 32'd0;
    timeout_hit  = 1'b0;
    if (state_reg == COLLECT) begin
      if (coin_valid) begin
        timeout_next = 32'd0;
      end else begin
        timeout_next = timeout_reg + 32'd1;
        timeout_hit  = (timeout_reg == 32'(TIMEOUT_CYCLES - 1));
      end
    end
  end

  // Timeout counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      timeout_reg <= 32'd0;
    end else begin
      timeout_reg <= timeout_next;
    end
  end
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
  assign timeout_hit = 1'b0;
`endif

  // Saturating credit; coins only count before the sale is committed.
  always_comb begin
    coin_sum          = {1'b0, balance_reg} + {1'b0, coin_value};
    coin_credited     = coin_sum[16] ? 16'hFFFF : coin_sum[15:0];
    coin_accept       = coin_valid && ((state_reg == IDLE) || (state_reg == FETCH) ||
                                       (state_reg == CHECK) || (state_reg == COLLECT));
    balance_with_coin = coin_accept ? coin_credited : balance_reg;
  end

  // Transaction sequencing and datapath next-values.
  always_comb begin
    state_next   = state_reg;
    addr_next    = addr_reg;
    balance_next = balance_with_coin;
    price_next   = price_reg;
    change_next  = change_reg;
    case (state_reg)
      IDLE: begin
        // A selection wins over a simultaneous cancel.
        if (sel_valid) begin
          addr_next  = sel_item;
          state_next = FETCH;
        end else if (cancel && (balance_with_coin != 16'd0)) begin
          change_next = balance_with_coin;
          state_next  = REFUND;
        end
      end
      FETCH: begin
        state_next = CHECK;
      end
      CHECK: begin
        price_next = item_price;
        state_next = item_reject ? IDLE : COLLECT;
      end
      COLLECT: begin
        // Cancel beats a payment that completes in the same cycle.
        if (cancel) begin
          change_next = balance_with_coin;
          state_next  = REFUND;
        end else if (balance_with_coin >= price_reg) begin
          state_next = DISPENSE;
        end else if (timeout_hit) begin
          change_next = balance_with_coin;
          state_next  = REFUND;
        end
      end
      DISPENSE: begin
        change_next = balance_reg - price_reg;
        state_next  = REFUND;
      end
      REFUND: begin
        balance_next = 16'd0;
        state_next   = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      addr_reg    <= '0;
      balance_reg <= 16'd0;
      price_reg   <= 16'd0;
      change_reg  <= 16'd0;
    end else begin
      state_reg   <= state_next;
      addr_reg    <= addr_next;
      balance_reg <= balance_next;
      price_reg   <= price_next;
      change_reg  <= change_next;
    end
  end

  // Strobes decode from the state, so at most one can be high in any cycle.
  assign dispense_valid = (state_reg == DISPENSE);
  assign change_valid   = (state_reg == REFUND);
  assign sel_error      = (state_reg == CHECK) && item_reject;
  assign busy           = (state_reg != IDLE);
  assign mem_addr       = addr_reg;
  assign balance        = balance_reg;
  assign change_amount  = change_reg;

endmodule

// File: tb/tb_vend_controller.sv
// Randomized self-checking bench for vend_controller with a transaction-level
// reference: each purchase is predicted as (reject | dispense + change | refund).
module tb_vend_controller;
  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst;
  logic          sel_valid;
  logic [AW-1:0] sel_item;
  logic          coin_valid;
  logic [15:0]   coin_value;
  logic          cancel;
  logic [31:0]   item_data_in;
  logic [AW-1:0] mem_addr;
  logic          dispense_valid;
  logic          change_valid;
  logic [15:0]   change_amount;
  logic          sel_error;
  logic [15:0]   balance;
  logic          busy;

  always #5 clk = ~clk;

  vend_controller #(
    .MAX_ITEMS(1024),
    .ITEM_ADDR_WIDTH(AW),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk), .rst(rst), .sel_valid(sel_valid), .sel_item(sel_item),
    .coin_valid(coin_valid), .coin_value(coin_value), .cancel(cancel),
    .item_data_in(item_data_in), .mem_addr(mem_addr),
    .dispense_valid(dispense_valid), .change_valid(change_valid),
    .change_amount(change_amount), .sel_error(sel_error),
    .balance(balance), .busy(busy)
  );

  // Item memory, registered read. Only the stimulus process writes it.
  logic [31:0] mem [0:1023];
  always @(posedge clk) item_data_in <= mem[mem_addr];

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Pulse monitor.
  int            disp_cnt = 0;
  int            chg_cnt  = 0;
  int            err_cnt  = 0;
  logic [AW-1:0] disp_addr = '0;
  logic [15:0]   chg_seen  = 16'd0;

  always @(negedge clk) begin
    if (dispense_valid || change_valid || sel_error)
      check("pulse_onehot", 32'($countones({dispense_valid, change_valid, sel_error})), 32'd1);
    if (dispense_valid) begin
      disp_cnt++;
      disp_addr = mem_addr;
    end
    if (change_valid) begin
      chg_cnt++;
      chg_seen = change_amount;
    end
    if (sel_error) err_cnt++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int sat_add(input int a, input int b);
    return (a + b > 65535) ? 65535 : a + b;
  endfunction

  // Reference state and the coin plan for the next transaction.
  int model_bal = 0;
  int plan_coin [8];
  int plan_n = 0;
  int plan_cancel_at = -1;
  bit plan_gaps = 1'b0;
  bit plan_timeout = 1'b0;

  task automatic idle_coin(input int v);
    coin_valid = 1'b1;
    coin_value = 16'(v);
    step();
    coin_valid = 1'b0;
    model_bal = sat_add(model_bal, v);
    check("idle_credit", balance, model_bal);
  endtask

  task automatic idle_cancel();
    int c0;
    int exp_chg;
    c0 = chg_cnt;
    exp_chg = model_bal;
    cancel = 1'b1;
    step();
    cancel = 1'b0;
    check("idle_cancel_busy", busy, 1);
    step();
    check("idle_cancel_pulse", chg_cnt - c0, 1);
    check("idle_cancel_amount", chg_seen, exp_chg);
    check("idle_cancel_bal", balance, 0);
    model_bal = 0;
    $display("txn idle-cancel refund=%0d", exp_chg);
  endtask

  task automatic run_txn(input int item);
    logic [31:0] rec;
    int price, exp_chg, d0, c0, e0, budget;
    bit ok, paid, cancelled, just_left;
    rec   = mem[item];
    price = int'(rec[15:0]);
    ok    = (rec[31:24] < rec[23:16]) && (price != 0);
    d0 = disp_cnt; c0 = chg_cnt; e0 = err_cnt;

    sel_valid = 1'b1;
    sel_item  = AW'(item);
    step();
    sel_valid = 1'b0;
    check("fetch_busy", busy, 1);
    step();
    check("sel_error_timing", sel_error, !ok);
    step();
    if (!ok) begin
      check("reject_pulses", err_cnt - e0, 1);
      check("reject_no_disp", disp_cnt - d0, 0);
      check("reject_balance", balance, model_bal);
      check("reject_idle", busy, 0);
      $display("txn item=%0d rejected balance=%0d", item, model_bal);
      return;
    end

    paid      = (model_bal >= price);
    cancelled = 1'b0;
    just_left = 1'b0;
    for (int i = 0; i < plan_n && !paid && !cancelled; i++) begin
      if (plan_gaps) repeat ($urandom_range(0, 2)) step();
      coin_valid = 1'b1;
      coin_value = 16'(plan_coin[i]);
      if (i == plan_cancel_at) cancel = 1'b1;
      model_bal = sat_add(model_bal, plan_coin[i]);
      step();
      coin_valid = 1'b0;
      cancel     = 1'b0;
      if (i == plan_cancel_at) cancelled = 1'b1;
      else if (model_bal >= price) paid = 1'b1;
      just_left = paid || cancelled;
    end
    if (!paid && !cancelled && !plan_timeout) begin
      cancel = 1'b1;
      step();
      cancel = 1'b0;
      cancelled = 1'b1;
      just_left = 1'b1;
    end
    // Inputs arriving in DISPENSE/REFUND must all be ignored.
    if (just_left) begin
      coin_valid = 1'b1;
      coin_value = 16'd7;
      cancel     = 1'b1;
      sel_valid  = 1'b1;
      sel_item   = AW'(item ^ 1);
      step();
      coin_valid = 1'b0;
      cancel     = 1'b0;
      sel_valid  = 1'b0;
    end

    exp_chg = paid ? model_bal - price : model_bal;
    budget = 0;
    while (chg_cnt == c0 && budget < 40) begin
      step();
      budget++;
    end
    check("change_pulse", chg_cnt - c0, 1);
    check("change_amount", chg_seen, exp_chg);
    check("dispense_count", disp_cnt - d0, paid ? 1 : 0);
    if (paid) check("dispense_addr", disp_addr, item);
    check("balance_cleared", balance, 0);
    check("idle_after", busy, 0);
    check("change_hold", change_amount, exp_chg);
    $display("txn item=%0d price=%0d paid=%0d change=%0d", item, price, paid, exp_chg);
    model_bal = 0;
    if (paid) begin
      rec[31:24] = rec[31:24] + 8'd1;
      mem[item]  = rec;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    rst = 1'b1; sel_valid = 1'b0; sel_item = '0; coin_valid = 1'b0;
    coin_value = 16'd0; cancel = 1'b0;
    for (int i = 0; i < 1024; i++) mem[i] = 32'd0;
    mem[3] = {8'd0, 8'd2, 16'd30};
    mem[4] = {8'd0, 8'd3, 16'd30};
    mem[5] = {8'd1, 8'd1, 16'd20};
    mem[6] = {8'd0, 8'd5, 16'd0};
    for (int i = 10; i < 18; i++) begin
      mem[i][31:24] = 8'($urandom_range(0, 2));
      mem[i][23:16] = 8'($urandom_range(0, 4));
      mem[i][15:0]  = ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom_range(1, 200));
    end

    repeat (3) step();
    check("rst_balance", balance, 0);
    check("rst_busy", busy, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_change_amount", change_amount, 0);
    check("rst_pulses", {dispense_valid, change_valid, sel_error}, 0);
    rst = 1'b0;
    step();

    // Two coins overpay price 30 by 10.
    plan_coin[0] = 20; plan_coin[1] = 20; plan_n = 2; plan_cancel_at = -1;
    plan_gaps = 1'b0; plan_timeout = 1'b0;
    run_txn(3);
    // Sold-out slot and unpriced slot.
    run_txn(5);
    run_txn(6);
    // Cancel together with a coin refunds both coins.
    plan_coin[0] = 10; plan_coin[1] = 5; plan_n = 2; plan_cancel_at = 1;
    run_txn(3);
    // Exact payment gives a zero-change pulse.
    plan_coin[0] = 30; plan_n = 1; plan_cancel_at = -1;
    run_txn(4);
    // Last unit of item 3, then it must be rejected as sold out.
    run_txn(3);
    run_txn(3);
    // Balance survives a rejected selection, then is refunded from IDLE.
    idle_coin(12);
    run_txn(5);
    idle_cancel();
    // Saturating credit.
    idle_coin(16'hFFF0);
    idle_coin(100);
    check("saturated_balance", balance, 16'hFFFF);
    idle_cancel();
    // Cancel with nothing credited does nothing.
    c0 = chg_cnt;
    cancel = 1'b1;
    step();
    cancel = 1'b0;
    step();
    check("cancel_zero_noop", chg_cnt - c0, 0);
    check("cancel_zero_idle", busy, 0);
    // Reset while collecting discards the balance silently.
    c0 = chg_cnt;
    sel_valid = 1'b1; sel_item = AW'(4);
    step();
    sel_valid = 1'b0;
    step();
    step();
    coin_valid = 1'b1; coin_value = 16'd10;
    step();
    coin_valid = 1'b0;
    check("collect_balance", balance, 10);
    check("collect_busy", busy, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midrst_balance", balance, 0);
    check("midrst_busy", busy, 0);
    check("midrst_mem_addr", mem_addr, 0);
    check("midrst_change_amount", change_amount, 0);
    step();
    step();
    check("midrst_no_change", chg_cnt - c0, 0);
    model_bal = 0;
    $display("txn reset-in-collect");

`ifdef VEND_TIMEOUT_EN
    plan_coin[0] = 10; plan_n = 1; plan_cancel_at = -1; plan_timeout = 1'b1;
    run_txn(4);
    plan_timeout = 1'b0;
`endif

    for (int t = 0; t < 60; t++) begin
      int item;
      int price;
      item = $urandom_range(10, 17);
      if ($urandom_range(0, 3) == 0) idle_coin($urandom_range(1, 40));
      if (model_bal > 0 && $urandom_range(0, 9) == 0) idle_cancel();
      price = int'(mem[item][15:0]);
      plan_n = $urandom_range(1, 8);
      for (int i = 0; i < 8; i++) plan_coin[i] = $urandom_range(1, price / 2 + 1);
      plan_cancel_at = ($urandom_range(0, 3) == 0) ? $urandom_range(0, plan_n - 1) : -1;
      plan_gaps = 1'b1;
      run_txn(item);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
